pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage rv32i pipeline (IF/ID/EX/MM/WB).

---
 rtl/rv32i_types.sv | 34 +++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
// Types shared by the pipeline control blocks.
//   hz_state_t   : outstanding-request state of the hazard sequencer. The
//                  encoding is {i_pend, d_pend}, so the two pending flags can
//                  be read straight off the state bits.
//   stage_ctrl_t : per-stage hold enables plus ID/EX bubble and IF/ID flush.
// -----------------------------------------------------------------------------
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_D  = 2'b01,
    WAIT_I  = 2'b10,
    WAIT_ID = 2'b11
  } hz_state_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mm;
    logic stall_wb;
    logic bubble_ex;
    logic flush_if_id;
  } stage_ctrl_t;

  // Every stage holds, nothing is killed: used while a memory access is in flight.
  localparam stage_ctrl_t CTRL_HOLD_ALL = '{
    stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1, stall_mm: 1'b1, stall_wb: 1'b1,
    bubble_ex: 1'b0, flush_if_id: 1'b0
  };

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at MAX. clr_i has priority over en_i.
// Ports:
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   en_i     : increment this cycle (ignored once q_o == MAX)
//   clr_i    : return to zero this cycle
//   q_o      : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    // NOTE: next-state gets a default before any branch so no path leaves it unassigned (no latch).
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i && (q_q != MAX)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers update with non-blocking assignments only.
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage rv32i pipeline (IF/ID/EX/MM/WB).
// Tracks one outstanding imem and one outstanding dmem request, holds the whole
// pipe while either is unanswered, and otherwise resolves EX redirects (flush
// IF/ID, bubble ID/EX) ahead of load-use hazards (hold IF/ID, bubble ID/EX).
// A fetch issued in the same cycle as an accepted redirect is wrong-path: its
// response is flagged for dropping and a refetch pulse follows one cycle later.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req_i / imem_resp_i fetch request pulse / fetch response valid
//   dmem_req_i / dmem_resp_i MM load/store pulse / data response valid
//   load_use_i               ID reads rd of a load in EX
//   redirect_i               EX resolves a taken branch/jump
//   stall_{if,id,ex,mm,wb}_o per-stage hold enables
//   bubble_ex_o              load ID/EX with an invalid NOP
//   flush_if_id_o            invalidate IF/ID
//   imem_resp_drop_o         current imem response is wrong-path
//   refetch_o                one-cycle pulse: reissue fetch at redirected PC
//   err_protocol_o           sticky: second request on a side already pending
//   err_timeout_o            sticky: TIMEOUT_CYCLES consecutive memory-stall cycles
//   perf_*_o                 event counters, present only with PERF_CNT_EN defined;
//                            otherwise tied to zero
// Configuration macro: PERF_CNT_EN
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned PERF_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_req_i,
  input  logic              imem_resp_i,
  input  logic              dmem_req_i,
  input  logic              dmem_resp_i,
  input  logic              load_use_i,
  input  logic              redirect_i,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              stall_ex_o,
  output logic              stall_mm_o,
  output logic              stall_wb_o,
  output logic              bubble_ex_o,
  output logic              flush_if_id_o,
  output logic              imem_resp_drop_o,
  output logic              refetch_o,
  output logic              err_protocol_o,
  output logic              err_timeout_o,
  output logic [PERF_W-1:0] perf_mem_stall_o,
  output logic [PERF_W-1:0] perf_lu_bubble_o,
  output logic [PERF_W-1:0] perf_flush_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  hz_state_t   state_q, state_d;
  logic        i_pend, d_pend, i_pend_d, d_pend_d;
  logic        mem_stall, redirect_acc, lu_acc;
  logic        drop_q, drop_d;
  logic        refetch_q, refetch_d;
  logic        err_protocol_q, err_protocol_d;
  logic        err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q;
  stage_ctrl_t ctrl;

  // Next-state and stage control.
  always_comb begin
    i_pend = 1'b0;
    d_pend = 1'b0;
    case (state_q)
      WAIT_I:  i_pend = 1'b1;
      WAIT_D:  d_pend = 1'b1;
      WAIT_ID: begin
        i_pend = 1'b1;
        d_pend = 1'b1;
      end
      default: ;
    endcase

    // A response retires the pending request; a request in the same cycle re-arms it.
    // A request with one still unanswered leaves the flag set and raises the error.
    i_pend_d = (i_pend & ~imem_resp_i) | imem_req_i;
    d_pend_d = (d_pend & ~dmem_resp_i) | dmem_req_i;
    state_d  = hz_state_t'({i_pend_d, d_pend_d});

    // Released in the very cycle the response arrives.
    mem_stall    = (i_pend & ~imem_resp_i) | (d_pend & ~dmem_resp_i);
    redirect_acc = ~mem_stall & redirect_i;
    lu_acc       = ~mem_stall & ~redirect_i & load_use_i;

    ctrl = '0;
    if (mem_stall) begin
      ctrl = CTRL_HOLD_ALL;
    end else if (redirect_acc) begin
      ctrl.flush_if_id = 1'b1;
      ctrl.bubble_ex   = 1'b1;
    end else if (lu_acc) begin
      ctrl.stall_if  = 1'b1;
      ctrl.stall_id  = 1'b1;
      ctrl.bubble_ex = 1'b1;
    end
    // Fetch must not advance until the wrong-path response has been swallowed.
    if (drop_q) ctrl.stall_if = 1'b1;

    drop_d    = (drop_q & ~imem_resp_i) | (imem_req_i & redirect_acc);
    refetch_d = drop_q & imem_resp_i;

    err_protocol_d = err_protocol_q
                   | (imem_req_i & i_pend & ~imem_resp_i)
                   | (dmem_req_i & d_pend & ~dmem_resp_i);
    // The count is about to reach TIMEOUT_CYCLES when it stands one short and we stall again.
    err_timeout_d  = err_timeout_q
                   | (mem_stall & (stall_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      drop_q         <= 1'b0;
      refetch_q      <= 1'b0;
      err_protocol_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      drop_q         <= drop_d;
      refetch_q      <= refetch_d;
      err_protocol_q <= err_protocol_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  sat_counter #(
    .W   (CNT_W),
    .MAX (CNT_W'(TIMEOUT_CYCLES))
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (mem_stall),
    .clr_i (~mem_stall),
    .q_o   (stall_cnt_q)
  );

  // NOTE: reset is synchronous, so registers still hold stale values during the rst cycle;
  // outputs are masked with rst to read as zero for the whole time reset is asserted.
  assign stall_if_o       = ~rst & ctrl.stall_if;
  assign stall_id_o       = ~rst & ctrl.stall_id;
  assign stall_ex_o       = ~rst & ctrl.stall_ex;
  assign stall_mm_o       = ~rst & ctrl.stall_mm;
  assign stall_wb_o       = ~rst & ctrl.stall_wb;
  assign bubble_ex_o      = ~rst & ctrl.bubble_ex;
  assign flush_if_id_o    = ~rst & ctrl.flush_if_id;
  assign imem_resp_drop_o = ~rst & drop_q & imem_resp_i;
  assign refetch_o        = ~rst & refetch_q;
  assign err_protocol_o   = ~rst & err_protocol_q;
  assign err_timeout_o    = ~rst & err_timeout_q;

`ifdef PERF_CNT_EN
  logic [PERF_W-1:0] perf_mem_stall_q, perf_lu_bubble_q, perf_flush_q;

  sat_counter #(.W(PERF_W)) u_perf_mem_stall (
    .clk(clk), .rst(rst), .en_i(mem_stall), .clr_i(1'b0), .q_o(perf_mem_stall_q)
  );
  sat_counter #(.W(PERF_W)) u_perf_lu_bubble (
    .clk(clk), .rst(rst), .en_i(lu_acc), .clr_i(1'b0), .q_o(perf_lu_bubble_q)
  );
  sat_counter #(.W(PERF_W)) u_perf_flush (
    .clk(clk), .rst(rst), .en_i(redirect_acc), .clr_i(1'b0), .q_o(perf_flush_q)
  );

  assign perf_mem_stall_o = rst ? '0 : perf_mem_stall_q;
  assign perf_lu_bubble_o = rst ? '0 : perf_lu_bubble_q;
  assign perf_flush_o     = rst ? '0 : perf_flush_q;
`else
  assign perf_mem_stall_o = '0;
  assign perf_lu_bubble_o = '0;
  assign perf_flush_o     = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed scenarios followed by constrained-random traffic, every cycle
// compared against a transaction-level reference model of the hazard rules.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int TO = 8;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req = 1'b0, imem_resp = 1'b0, dmem_req = 1'b0, dmem_resp = 1'b0;
  logic load_use = 1'b0, redirect = 1'b0;
  logic stall_if, stall_id, stall_ex, stall_mm, stall_wb;
  logic bubble_ex, flush_if_id, imem_resp_drop, refetch, err_protocol, err_timeout;
  logic [PW-1:0] perf_mem_stall, perf_lu_bubble, perf_flush;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .PERF_W(PW)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_i       (imem_req),
    .imem_resp_i      (imem_resp),
    .dmem_req_i       (dmem_req),
    .dmem_resp_i      (dmem_resp),
    .load_use_i       (load_use),
    .redirect_i       (redirect),
    .stall_if_o       (stall_if),
    .stall_id_o       (stall_id),
    .stall_ex_o       (stall_ex),
    .stall_mm_o       (stall_mm),
    .stall_wb_o       (stall_wb),
    .bubble_ex_o      (bubble_ex),
    .flush_if_id_o    (flush_if_id),
    .imem_resp_drop_o (imem_resp_drop),
    .refetch_o        (refetch),
    .err_protocol_o   (err_protocol),
    .err_timeout_o    (err_timeout),
    .perf_mem_stall_o (perf_mem_stall),
    .perf_lu_bubble_o (perf_lu_bubble),
    .perf_flush_o     (perf_flush)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: outstanding transactions per side, whether the fetch in
  // flight is wrong-path, a refetch owed, run length of memory waits, events.
  int     m_i_out = 0, m_d_out = 0;
  bit     m_wrong_path = 0, m_refetch_due = 0;
  bit     m_proto_err = 0, m_to_err = 0;
  int     m_wait_run = 0;
  longint m_n_wait = 0, m_n_lu = 0, m_n_flush = 0;

  // One clock: apply inputs after the falling edge, compare, then advance the model at the rising edge.
  task automatic cycle(input bit r, input bit ir, input bit iresp, input bit dr, input bit dresp,
                       input bit lu, input bit rd, input string tag);
    bit waiting;
    bit [10:0] exp_ctrl, got_ctrl;
    logic [95:0] exp_perf, got_perf;
    @(negedge clk);
    rst = r; imem_req = ir; imem_resp = iresp; dmem_req = dr; dmem_resp = dresp;
    load_use = lu; redirect = rd;
    #1;
    waiting = (m_i_out > 0 && !iresp) || (m_d_out > 0 && !dresp);
    exp_ctrl = '0;
    if (!r) begin
      if (waiting)  exp_ctrl[10:4] = 7'b11111_00;
      else if (rd)  exp_ctrl[10:4] = 7'b00000_11;
      else if (lu)  exp_ctrl[10:4] = 7'b11000_10;
      if (m_wrong_path) exp_ctrl[10] = 1'b1;
      exp_ctrl[3] = m_wrong_path && iresp;
      exp_ctrl[2] = m_refetch_due;
      exp_ctrl[1] = m_proto_err;
      exp_ctrl[0] = m_to_err;
    end
    got_ctrl = {stall_if, stall_id, stall_ex, stall_mm, stall_wb, bubble_ex, flush_if_id,
                imem_resp_drop, refetch, err_protocol, err_timeout};
    check({tag, ".ctrl"}, {117'd0, got_ctrl}, {117'd0, exp_ctrl});
`ifdef PERF_CNT_EN
    exp_perf = r ? 96'd0 : {m_n_wait[PW-1:0], m_n_lu[PW-1:0], m_n_flush[PW-1:0]};
`else
    exp_perf = 96'd0;
`endif
    got_perf = {perf_mem_stall, perf_lu_bubble, perf_flush};
    check({tag, ".perf"}, {32'd0, got_perf}, {32'd0, exp_perf});
    @(posedge clk);
    if (r) begin
      m_i_out = 0; m_d_out = 0; m_wrong_path = 0; m_refetch_due = 0;
      m_proto_err = 0; m_to_err = 0; m_wait_run = 0;
      m_n_wait = 0; m_n_lu = 0; m_n_flush = 0;
    end else begin
      if (ir && m_i_out == 1 && !iresp) m_proto_err = 1;
      if (dr && m_d_out == 1 && !dresp) m_proto_err = 1;
      m_i_out = ((m_i_out == 1 && !iresp) || ir) ? 1 : 0;
      m_d_out = ((m_d_out == 1 && !dresp) || dr) ? 1 : 0;
      m_refetch_due = m_wrong_path && iresp;
      m_wrong_path  = (m_wrong_path && !iresp) || (ir && rd && !waiting);
      if (waiting) begin
        if (m_wait_run + 1 >= TO) m_to_err = 1;
        m_wait_run = (m_wait_run + 1 > TO) ? TO : m_wait_run + 1;
        m_n_wait++;
      end else begin
        m_wait_run = 0;
        if (rd)      m_n_flush++;
        else if (lu) m_n_lu++;
      end
    end
  endtask

  initial begin
    // args: rst, imem_req, imem_resp, dmem_req, dmem_resp, load_use, redirect
    cycle(1, 0, 0, 0, 0, 0, 0, "reset");
    cycle(1, 0, 0, 0, 0, 1, 1, "reset_masked");
    cycle(0, 0, 0, 0, 0, 0, 0, "idle");

    // Fetch waits three cycles.
    cycle(0, 1, 0, 0, 0, 0, 0, "t1_c0");
    cycle(0, 0, 0, 0, 0, 0, 0, "t1_c1");
    cycle(0, 0, 0, 0, 0, 0, 0, "t1_c2");
    cycle(0, 0, 1, 0, 0, 0, 0, "t1_c3");
    cycle(0, 0, 0, 0, 0, 0, 0, "t1_c4");

    // Both sides outstanding, data answers first.
    cycle(0, 1, 0, 1, 0, 0, 0, "t2_c0");
    cycle(0, 0, 0, 0, 0, 0, 0, "t2_c1");
    cycle(0, 0, 0, 0, 1, 0, 0, "t2_c2");
    cycle(0, 0, 0, 0, 0, 0, 0, "t2_c3");
    cycle(0, 0, 1, 0, 0, 0, 0, "t2_c4");
    cycle(0, 0, 0, 0, 0, 0, 0, "t2_c5");

    // Load-use bubble with nothing pending.
    cycle(0, 0, 0, 0, 0, 1, 0, "t3_lu");
    cycle(0, 0, 0, 0, 0, 0, 0, "t3_after");

    // Redirect with a same-cycle fetch: wrong-path response dropped, refetch follows.
    cycle(0, 1, 0, 0, 0, 0, 1, "t4_redir");
    cycle(0, 0, 0, 0, 0, 0, 0, "t4_wait1");
    cycle(0, 0, 0, 0, 0, 0, 0, "t4_wait2");
    cycle(0, 0, 1, 0, 0, 0, 0, "t4_drop");
    cycle(0, 0, 0, 0, 0, 0, 0, "t4_refetch");
    cycle(0, 0, 0, 0, 0, 0, 0, "t4_after");

    // Redirect and load-use held through a data wait; flush wins on release.
    cycle(0, 0, 0, 1, 0, 0, 0, "t5_dreq");
    cycle(0, 0, 0, 0, 0, 1, 1, "t5_hold");
    cycle(0, 0, 0, 0, 1, 1, 1, "t5_release");
    cycle(0, 0, 0, 0, 0, 0, 0, "t5_after");

    // Back-to-back on one side is legal when the response lands in the same cycle.
    cycle(0, 0, 0, 1, 0, 0, 0, "b2b_c0");
    cycle(0, 0, 0, 1, 1, 0, 0, "b2b_c1");
    cycle(0, 0, 0, 0, 1, 0, 0, "b2b_c2");

    // Data never answers: timeout on the TO-th stall cycle, then a protocol error.
    cycle(0, 0, 0, 1, 0, 0, 0, "t6_dreq");
    for (int i = 1; i <= TO + 1; i++) cycle(0, 0, 0, 0, 0, 0, 0, $sformatf("t6_stall%0d", i));
    cycle(0, 0, 0, 1, 0, 0, 0, "t6_dreq2");
    cycle(0, 0, 0, 0, 0, 0, 0, "t6_proto");
    cycle(1, 0, 0, 0, 0, 0, 0, "t6_rst");
    cycle(0, 0, 0, 0, 1, 0, 0, "t6_stale_resp");
    cycle(0, 0, 1, 0, 0, 0, 0, "t6_stale_iresp");
    cycle(0, 0, 0, 0, 0, 0, 0, "t6_after");

    // Mostly legal random traffic with occasional protocol slips, stray responses and resets.
    for (int n = 0; n < 3000; n++) begin
      bit r, ir, iresp, dr, dresp, lu, rd;
      r     = ($urandom_range(0, 199) == 0);
      iresp = (m_i_out > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      dresp = (m_d_out > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      ir    = ($urandom_range(0, 2) == 0);
      dr    = ($urandom_range(0, 3) == 0);
      if (m_i_out > 0 && !iresp && $urandom_range(0, 29) != 0) ir = 0;
      if (m_d_out > 0 && !dresp && $urandom_range(0, 29) != 0) dr = 0;
      lu    = ($urandom_range(0, 3) == 0);
      rd    = ($urandom_range(0, 4) == 0);
      cycle(r, ir, iresp, dr, dresp, lu, rd, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
